player_sprite_writer: RTL
=========================

# player_sprite_writer

Frame-synchronised writer into the video memory that the VGA scan-out path reads. Once per frame, at the falling edge of vertical sync, it erases the player sprite at its previously drawn position and redraws it at the current `player_x`/`player_y`. It sits between the PS/2-driven player logic and the framebuffer write port, so the display shows a moving player without tearing during active video.

## Interface
- `COLOR_DEPTH`, 9, framebuffer pixel width (3 bits per RGB channel)
- `nX`, 10, x coordinate width
- `nY`, 9, y coordinate width
- `Mn`, 19, framebuffer address width
- `COLS`, 640, framebuffer columns
- `ROWS`, 480, framebuffer rows
- `SPRITE_W`, 8, sprite width in pixels
- `SPRITE_H`, 8, sprite height in pixels
- `BG_COLOR`, 9'b000000000, erase colour
- `PLAYER_COLOR`, 9'b111111000, sprite colour

Ports:
- `vga_clock` in 1: the single clock. Same 25 MHz pixel clock as scan-out.
- `resetn` in 1: asynchronous, active-low reset.
- `vga_vs_n` in 1: active-low vertical sync from the scan-out controller.
- `player_x` in nX: sprite top-left x.
- `player_y` in nY: sprite top-left y.
- `mem_ready` in 1: framebuffer accepts the write this cycle.
- `write_en` out 1: write request.
- `write_address` out Mn: equals y*COLS + x.
- `write_color` out COLOR_DEPTH: pixel data.
- `busy` out 1: a pass is in progress.
- `done` out 1: one-cycle pulse at the end of each pass.

## Operation
- **Trigger.** `vga_vs_n` is registered, and a falling edge (previous 1, current 0) is the trigger.
  - A trigger in IDLE starts a pass.
  - A trigger while `busy` sets `pending`. It does not accumulate.
  - `pending` starts a new pass on the cycle after DONE.
- **States.** IDLE → LATCH → (ERASE) → DRAW → DONE → IDLE.
- **LATCH.** Captures `player_x`/`player_y` into `new_x`/`new_y`.
  - If `old_valid` is set and new equals old: go to DONE with no writes.
  - Else if `old_valid`: go to ERASE.
  - Else: go to DRAW.
- **ERASE.** Scans the `old_x`/`old_y` rectangle row-major, writing `BG_COLOR`.
- **DRAW.** Scans the `new_x`/`new_y` rectangle, writing `PLAYER_COLOR`.
  - On the last accepted write: old ← new and `old_valid` ← 1.
- **Scan.** The column counter runs 0..SPRITE_W-1. Row increments on column wrap. The rectangle ends after row SPRITE_H-1.
- **Clipping.** Pixels with x ≥ COLS or y ≥ ROWS produce no write. The counter advances one cycle per clipped pixel.
- **Address arithmetic.** Computed at Mn bits, with no truncation for in-range pixels. Coordinate sums use nX+1 / nY+1 bits so the clip compare cannot wrap.
- **Reset.**
  - Outputs: `write_en`=0, `write_address`=0, `write_color`=0, `busy`=0, `done`=0.
  - Internal: state IDLE, `pending`=0, `old_valid`=0.
  - Reset mid-pass abandons the pass. The next pass performs no erase.

## Timing
- The falling edge is sampled at cycle N, LATCH occurs at N+1, and the first `write_en` is at N+2.
- All outputs are registered.
- `busy` is high from LATCH through DONE inclusive.
- **Handshake.** A write is accepted when `write_en && mem_ready`.
  - While `mem_ready`=0, `write_en`, `write_address` and `write_color` hold stable.
  - The counter advances only on acceptance or on a clipped pixel.
- **Throughput.** With `mem_ready` held at 1, one pixel per cycle. A full move takes 2·SPRITE_W·SPRITE_H write cycles (128 for the default sprite), well inside the 36000-cycle vertical blank.
- `done` pulses in the DONE cycle.
  - Normal pass: the cycle after the last accepted write.
  - Unchanged-position pass: at N+2.

## Configuration
- `PLAYER_BITMAP_EN` defined:
  - DRAW takes colour from a SPRITE_W×SPRITE_H one-bit bitmap ROM.
  - A 0 bit is transparent: no write, one cycle spent.
  - ERASE still clears the full rectangle.
- `PLAYER_BITMAP_EN` undefined: DRAW writes a solid `PLAYER_COLOR` rectangle.

## Structure
- **Shared video package** holds:
  - the FSM state enum
  - COLS/ROWS/COLOR_DEPTH constants
  - the BG/PLAYER colour constants
  - the bitmap ROM contents under `PLAYER_BITMAP_EN`
- **One sub-module, `sprite_scan_counter`:**
  - inputs: origin, start, advance
  - outputs: pixel x/y, clipped flag, last flag
  - instantiated once and reused for both ERASE and DRAW.
- Address multiply is y·COLS + x in the top level, matching the framebuffer's address mapping.

## Test plan
- **First draw.** After reset, first `vga_vs_n` fall with player (100,50), `mem_ready`=1 → no BG writes. 64 `PLAYER_COLOR` writes from address 32100 to 36587, row stride 640. `done` the cycle after.
- **One-pixel move.** Next fall with player (101,50) → 64 BG writes from 32100, then 64 player writes from 32101. `done` follows the 128th write.
- **No move.** Next fall at the same position → zero writes, `done` at N+2.
- **Backpressure.** `mem_ready` low for 5 cycles mid-DRAW → outputs frozen. 64 writes still occur, with `done` 5 cycles later.
- **Clipping.** Player at (636,476) → 16 writes, x 636..639 and y 476..479. The pass still takes 64 cycles.
- **Reset and retrigger.** Reset asserted mid-ERASE → all outputs 0 immediately. Next fall redraws with no erase. A trigger during `busy` causes exactly one extra pass.

Source files
------------

// File: rtl/player_sprite_writer_pkg.sv
// Shared video constants, writer FSM state type and the optional sprite bitmap ROM.
// The bitmap ROM is compiled in only when PLAYER_BITMAP_EN is defined.
package player_sprite_writer_pkg;

    localparam int unsigned COLS        = 640;
    localparam int unsigned ROWS        = 480;
    localparam int unsigned COLOR_DEPTH = 9;

    localparam logic [COLOR_DEPTH-1:0] BG_COLOR     = 9'b000000000;
    localparam logic [COLOR_DEPTH-1:0] PLAYER_COLOR = 9'b111111000;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StErase,
        StDraw,
        StDone
    } wr_state_e;

`ifdef PLAYER_BITMAP_EN
    // One row per entry, bit index = sprite column.
    localparam logic [7:0] PLAYER_BITMAP [8] = '{
        8'b00111100,
        8'b01111110,
        8'b11011011,
        8'b11111111,
        8'b11111111,
        8'b01100110,
        8'b11000011,
        8'b10000001
    };

    function automatic logic bitmap_bit(input logic [2:0] row, input logic [2:0] col);
        return PLAYER_BITMAP[row][col];
    endfunction
`endif

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major column/row scanner over a SPRITE_W x SPRITE_H rectangle. Pixel and clip outputs
// describe the slot the counter moves to at the next edge; o_last describes the current slot.
module sprite_scan_counter
    import player_sprite_writer_pkg::*;
#(
    parameter int unsigned nX       = 10,
    parameter int unsigned nY       = 9,
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 8
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic [nX-1:0] i_origin_x,
    input  logic [nY-1:0] i_origin_y,
    input  logic          i_start,
    input  logic          i_advance,
    output logic [nX:0]   o_px_x,
    output logic [nY:0]   o_px_y,
    output logic          o_clipped,
    output logic          o_last
);

    localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (i_start) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (i_advance) begin
            if (r_col == CW'(SPRITE_W - 1)) begin
                w_col_nxt = '0;
                w_row_nxt = r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    // One extra bit so a sprite hanging off the right/bottom edge cannot wrap the compare.
    assign o_px_x    = {1'b0, i_origin_x} + (nX+1)'(w_col_nxt);
    assign o_px_y    = {1'b0, i_origin_y} + (nY+1)'(w_row_nxt);
    assign o_clipped = (o_px_x >= (nX+1)'(COLS)) || (o_px_y >= (nY+1)'(ROWS));
    assign o_last    = (r_col == CW'(SPRITE_W - 1)) && (r_row == RW'(SPRITE_H - 1));

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

endmodule

// File: rtl/player_sprite_writer.sv
// Once per frame (vsync fall) erases the player sprite at its old spot and redraws it.
// Define PLAYER_BITMAP_EN to draw from the bitmap ROM instead of a solid rectangle.
module player_sprite_writer
    import player_sprite_writer_pkg::*;
#(
    parameter int unsigned nX       = 10,
    parameter int unsigned nY       = 9,
    parameter int unsigned Mn       = 19,
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 8
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    input  logic                   vga_vs_n,
    input  logic [nX-1:0]          player_x,
    input  logic [nY-1:0]          player_y,
    input  logic                   mem_ready,
    output logic                   write_en,
    output logic [Mn-1:0]          write_address,
    output logic [COLOR_DEPTH-1:0] write_color,
    output logic                   busy,
    output logic                   done
);

    wr_state_e r_state;
    logic      r_vs, r_vs_prev, r_pending, r_old_valid;
    logic      r_busy, r_done, r_write_en;
    logic [Mn-1:0]          r_write_address;
    logic [COLOR_DEPTH-1:0] r_write_color;
    logic [nX-1:0] r_old_x, r_new_x, w_org_x;
    logic [nY-1:0] r_old_y, r_new_y, w_org_y;

    logic          w_trigger, w_same, w_slot_done, w_start, w_advance, w_draw_slot;
    logic          w_clipped, w_last, w_pix_we;
    logic [nX:0]   w_px_x;
    logic [nY:0]   w_px_y;
    logic [Mn-1:0] w_addr;

    assign w_trigger   = r_vs_prev & ~r_vs;
    assign w_same      = r_old_valid && (player_x == r_old_x) && (player_y == r_old_y);
    // A slot ends when nothing is requested (clipped/transparent) or the write is taken.
    assign w_slot_done = ~r_write_en | mem_ready;

    always_comb begin
        w_start     = 1'b0;
        w_advance   = 1'b0;
        w_draw_slot = 1'b1;
        w_org_x     = r_new_x;
        w_org_y     = r_new_y;
        case (r_state)
            StLatch: begin
                w_start = 1'b1;
                if (r_old_valid) begin
                    w_draw_slot = 1'b0;
                    w_org_x     = r_old_x;
                    w_org_y     = r_old_y;
                end else begin
                    w_org_x = player_x;
                    w_org_y = player_y;
                end
            end
            StErase: begin
                w_draw_slot = 1'b0;
                w_org_x     = r_old_x;
                w_org_y     = r_old_y;
                if (w_slot_done && w_last) begin
                    w_start     = 1'b1;
                    w_draw_slot = 1'b1;
                    w_org_x     = r_new_x;
                    w_org_y     = r_new_y;
                end else if (w_slot_done) begin
                    w_advance = 1'b1;
                end
            end
            StDraw: w_advance = w_slot_done & ~w_last;
            default: ;
        endcase
    end

    sprite_scan_counter #(
        .nX       (nX),
        .nY       (nY),
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_scan (
        .i_clk      (vga_clock),
        .i_resetn   (resetn),
        .i_origin_x (w_org_x),
        .i_origin_y (w_org_y),
        .i_start    (w_start),
        .i_advance  (w_advance),
        .o_px_x     (w_px_x),
        .o_px_y     (w_px_y),
        .o_clipped  (w_clipped),
        .o_last     (w_last)
    );

    assign w_addr = Mn'(w_px_y) * Mn'(COLS) + Mn'(w_px_x);

`ifdef PLAYER_BITMAP_EN
    logic w_bit;
    assign w_bit    = bitmap_bit(3'(w_px_y - {1'b0, w_org_y}), 3'(w_px_x - {1'b0, w_org_x}));
    assign w_pix_we = ~w_clipped & (~w_draw_slot | w_bit);
`else
    assign w_pix_we = ~w_clipped;
`endif

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_state         <= StIdle;
            r_vs            <= 1'b0;
            r_vs_prev       <= 1'b0;
            r_pending       <= 1'b0;
            r_old_valid     <= 1'b0;
            r_old_x         <= '0;
            r_old_y         <= '0;
            r_new_x         <= '0;
            r_new_y         <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_write_en      <= 1'b0;
            r_write_address <= '0;
            r_write_color   <= '0;
        end else begin
            r_vs      <= vga_vs_n;
            r_vs_prev <= r_vs;
            r_done    <= 1'b0;
            if (w_trigger && r_busy) r_pending <= 1'b1;
            case (r_state)
                StIdle: begin
                    if (w_trigger) begin
                        r_state <= StLatch;
                        r_busy  <= 1'b1;
                    end
                end
                StLatch: begin
                    r_new_x <= player_x;
                    r_new_y <= player_y;
                    if (w_same) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state         <= r_old_valid ? StErase : StDraw;
                        r_write_en      <= w_pix_we;
                        r_write_address <= w_addr;
                        r_write_color   <= w_draw_slot ? PLAYER_COLOR : BG_COLOR;
                    end
                end
                StErase: begin
                    if (w_slot_done) begin
                        if (w_last) r_state <= StDraw;
                        r_write_en      <= w_pix_we;
                        r_write_address <= w_addr;
                        r_write_color   <= w_draw_slot ? PLAYER_COLOR : BG_COLOR;
                    end
                end
                StDraw: begin
                    if (w_slot_done && w_last) begin
                        r_state     <= StDone;
                        r_done      <= 1'b1;
                        r_write_en  <= 1'b0;
                        r_old_x     <= r_new_x;
                        r_old_y     <= r_new_y;
                        r_old_valid <= 1'b1;
                    end else if (w_slot_done) begin
                        r_write_en      <= w_pix_we;
                        r_write_address <= w_addr;
                        r_write_color   <= PLAYER_COLOR;
                    end
                end
                StDone: begin
                    if (r_pending || w_trigger) begin
                        r_state   <= StLatch;
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign write_en      = r_write_en;
    assign write_address = r_write_address;
    assign write_color   = r_write_color;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
